// File: rtl/wb_write_queue.sv
// Writeback write queue: circular FIFO in front of the register file write port,
// with optional pending-write forwarding to the read ports (enabled by WBQ_BYPASS_EN).
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InReg,
  input  logic [31:0] InData,
  input  logic        DrainEn,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Bypass1,
  output logic        Bypass2,
  output logic [31:0] BypassData1,
  output logic [31:0] BypassData2,
  output logic [$clog2(DEPTH):0] Count,
  output logic        Empty,
  output logic        Full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign Count   = count;
  assign Empty   = (count == '0);
  assign Full    = (count == CW'(DEPTH));
  assign InReady = !Full && !Reset;

  // Writes to $0 complete the handshake but are dropped here
  assign doPush = InValid && InReady && (InReg != 5'd0);
  assign doPop  = !Empty && DrainEn;

  always_ff @(posedge Clk) begin
    if (doPush) begin
      regMem[tail]  <= InReg;
      dataMem[tail] <= InData;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      if (doPush) begin
        tail <= tail + 1'b1;
      end
      if (doPop) begin
        head          <= head + 1'b1;
        WriteRegister <= regMem[head];
        WriteData     <= dataMem[head];
      end
      RegWrite <= doPop;
      count    <= count + CW'(doPush) - CW'(doPop);
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to newest so the last match (closest to tail) wins over the output stage
  function automatic logic [32:0] lookup(input logic [4:0] rr);
    logic [32:0]   r;
    logic [PW-1:0] idx;
    r = '0;
    if (rr != 5'd0) begin
      if (RegWrite && (WriteRegister == rr)) r = {1'b1, WriteData};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (regMem[idx] == rr)) r = {1'b1, dataMem[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {Bypass1, BypassData1} = lookup(ReadRegister1);
    {Bypass2, BypassData2} = lookup(ReadRegister2);
  end
`else
  logic unusedReads;
  assign unusedReads = ^{ReadRegister1, ReadRegister2};
  assign Bypass1     = 1'b0;
  assign Bypass2     = 1'b0;
  assign BypassData1 = 32'd0;
  assign BypassData2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed plan scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InReg = '0;
  logic [31:0] InData = '0;
  logic        DrainEn = 1'b0;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic        Bypass1, Bypass2;
  logic [31:0] BypassData1, BypassData2;
  logic [2:0]  Count;
  logic        Empty, Full;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InReg(InReg), .InData(InData), .DrainEn(DrainEn),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Bypass1(Bypass1), .Bypass2(Bypass2),
    .BypassData1(BypassData1), .BypassData2(BypassData2),
    .Count(Count), .Empty(Empty), .Full(Full)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } Entry;

  Entry        q[$];
  logic        mRegWrite;
  logic [4:0]  mWReg;
  logic [31:0] mWData;
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Newest pending write to rr: youngest queue entry first, then the output stage
  function automatic void expBypass(input logic [4:0] rr, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = 32'd0;
`ifdef WBQ_BYPASS_EN
    if (rr != 5'd0) begin
      for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
        if (q[i].r == rr) begin
          hit = 1'b1;
          d   = q[i].d;
        end
      end
      if (!hit && mRegWrite && mWReg == rr) begin
        hit = 1'b1;
        d   = mWData;
      end
    end
`endif
  endfunction

  task automatic checkAll(input string tag);
    logic        h1, h2;
    logic [31:0] d1, d2;
    expBypass(ReadRegister1, h1, d1);
    expBypass(ReadRegister2, h2, d2);
    checkOutput({tag, ".InReady"}, InReady, (q.size() < DEPTH) && !Reset);
    checkOutput({tag, ".Count"}, Count, q.size());
    checkOutput({tag, ".Empty"}, Empty, q.size() == 0);
    checkOutput({tag, ".Full"}, Full, q.size() == DEPTH);
    checkOutput({tag, ".RegWrite"}, RegWrite, mRegWrite);
    checkOutput({tag, ".WriteRegister"}, WriteRegister, mWReg);
    checkOutput({tag, ".WriteData"}, WriteData, mWData);
    checkOutput({tag, ".Bypass1"}, Bypass1, h1);
    checkOutput({tag, ".BypassData1"}, BypassData1, d1);
    checkOutput({tag, ".Bypass2"}, Bypass2, h2);
    checkOutput({tag, ".BypassData2"}, BypassData2, d2);
  endtask

  // Drive one cycle of inputs, check pre-edge outputs, then advance the model across the edge
  task automatic applyStimulus(input string tag, input logic rst, input logic valid,
                               input logic [4:0] rg, input logic [31:0] data, input logic drain,
                               input logic [4:0] rr1, input logic [4:0] rr2);
    logic pushNow, popNow;
    Entry e;
    Reset = rst; InValid = valid; InReg = rg; InData = data; DrainEn = drain;
    ReadRegister1 = rr1; ReadRegister2 = rr2;
    #1;
    checkAll(tag);
    @(posedge Clk);
    if (rst) begin
      q.delete();
      mRegWrite = 1'b0; mWReg = 5'd0; mWData = 32'd0;
    end else begin
      popNow  = (q.size() > 0) && drain;
      pushNow = valid && (q.size() < DEPTH) && (rg != 5'd0);
      if (popNow) begin
        e = q.pop_front();
        mWReg = e.r; mWData = e.d;
      end
      mRegWrite = popNow;
      if (pushNow) q.push_back('{r: rg, d: data});
    end
    #1;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    q.delete();
    mRegWrite = 1'b0; mWReg = 5'd0; mWData = 32'd0;
    applyStimulus("rst", 1, 0, 0, 0, 0, 0, 0);

    // Single write latency
    applyStimulus("p1push", 0, 1, 16, 32'h03C1F0EA, 1, 16, 0);
    checkOutput("p1CountN", Count, 1);
    applyStimulus("p1pop", 0, 0, 0, 0, 1, 16, 0);
    checkOutput("p1RegWrite", RegWrite, 1);
    checkOutput("p1WriteRegister", WriteRegister, 16);
    checkOutput("p1WriteData", WriteData, 32'h03C1F0EA);
    applyStimulus("p1idle", 0, 0, 0, 0, 1, 16, 0);
    checkOutput("p1Empty", Empty, 1);

    // Fill with drain held off, then overflow attempt, then drain in order
    for (int i = 8; i <= 11; i++) applyStimulus("p2fill", 0, 1, 5'(i), 32'(i), 0, 9, 11);
    checkOutput("p2Full", Full, 1);
    checkOutput("p2InReady", InReady, 0);
    applyStimulus("p2over", 0, 1, 12, 32'hC, 0, 12, 8);
    for (int i = 8; i <= 11; i++) begin
      applyStimulus("p2drain", 0, 0, 0, 0, 1, 10, 11);
      checkOutput("p2Order", WriteRegister, 5'(i));
    end
    applyStimulus("p2tail", 0, 0, 0, 0, 1, 0, 0);

    // Forwarding of the newer of two writes to the same register
    applyStimulus("p3a", 0, 1, 13, 32'h1, 0, 13, 0);
    applyStimulus("p3b", 0, 1, 13, 32'h2, 0, 13, 0);
    for (int i = 0; i < 4; i++) applyStimulus("p3drain", 0, 0, 0, 0, 1, 13, 13);

    // Writes to $0 are accepted and dropped
    applyStimulus("p4zero", 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    checkOutput("p4Count", Count, 0);
    applyStimulus("p4after", 0, 0, 0, 0, 1, 0, 0);
    checkOutput("p4NoWrite", RegWrite, 0);

    // Reset in the middle of a drain
    for (int i = 1; i <= 3; i++) applyStimulus("p5fill", 0, 1, 5'(20 + i), 32'(100 + i), 0, 21, 23);
    applyStimulus("p5drain", 0, 0, 0, 0, 1, 22, 21);
    applyStimulus("p5reset", 1, 1, 7, 32'h7, 1, 22, 23);
    checkOutput("p5Count", Count, 0);
    checkOutput("p5RegWrite", RegWrite, 0);
    for (int i = 0; i < 3; i++) applyStimulus("p5after", 0, 0, 0, 0, 1, 22, 23);

    // Random traffic on a small register set to provoke forwarding hits
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 2) != 0,
                    5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
